// File: rtl/state_dispatcher_if.sv
// ---------------------------------------------------------------------------
// state_dispatcher_if
//   Bus bundle between the state dispatcher and its two neighbours: the
//   InexRecur state regfile (random read + append write) and the InexRecur
//   engine (dispatch valid/ready plus a one-cycle response strobe).
//
//   master : the dispatcher side
//   slave  : regfile/engine side (or a testbench standing in for them)
//
//   Regfile : st_ran_re/st_ran_addr -> st_rdata (one cycle later),
//             st_we/st_wdata append, st_full back-pressure
//   Engine  : disp_valid/disp_ready with disp_pos/disp_addr/disp_idx,
//             resp_valid/resp_push/resp_state
// ---------------------------------------------------------------------------
interface state_dispatcher_if #(
    parameter int POS_W  = 5,
    parameter int ADDR_W = 12,
    parameter int DW     = POS_W + ADDR_W + 1
) ();
    // regfile
    logic              st_ran_re;
    logic [ADDR_W-1:0] st_ran_addr;
    logic [DW-1:0]     st_rdata;
    logic              st_full;
    logic              st_we;
    logic [DW-1:0]     st_wdata;
    // engine request
    logic              disp_valid;
    logic              disp_ready;
    logic [POS_W-1:0]  disp_pos;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] disp_idx;
    // engine response
    logic              resp_valid;
    logic              resp_push;
    logic [DW-1:0]     resp_state;

    modport master (
        output st_ran_re, st_ran_addr, st_we, st_wdata,
               disp_valid, disp_pos, disp_addr, disp_idx,
        input  st_rdata, st_full, disp_ready,
               resp_valid, resp_push, resp_state
    );

    modport slave (
        input  st_ran_re, st_ran_addr, st_we, st_wdata,
               disp_valid, disp_pos, disp_addr, disp_idx,
        output st_rdata, st_full, disp_ready,
               resp_valid, resp_push, resp_state
    );
endinterface

// File: rtl/state_dispatcher.sv
// ---------------------------------------------------------------------------
// state_dispatcher
//   Scans the first num entries of the InexRecur state regfile. Finished
//   entries (end bit set) are skipped; unfinished ones are handed to the
//   InexRecur engine one at a time. Each engine response may carry a child
//   state, which is appended to the regfile (dropped and flagged if the
//   regfile is full). A done pulse closes the pass; statistics hold until
//   the next accepted start.
//
//   State layout: {pos[DW-1 -: POS_W], addr[ADDR_W:1], end[0]}
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i, num_i   begin a pass over entries 0..num_i-1 (IDLE only)
//   bus              regfile + engine bundle (master side)
//   busy_o           pass in progress (not IDLE, not DONE)
//   done_o           one-cycle end-of-pass pulse
//   disp_cnt_o       entries dispatched this pass
//   skip_cnt_o       entries skipped this pass
//   push_cnt_o       child states written this pass
//   overflow_o       sticky: a child state was dropped on st_full
// ---------------------------------------------------------------------------
module state_dispatcher #(
    parameter int POS_W  = 5,
    parameter int ADDR_W = 12,
    parameter int DW     = POS_W + ADDR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  num_i,
    state_dispatcher_if.master bus,
    output logic               busy_o,
    output logic               done_o,
    output logic [ADDR_W:0]    disp_cnt_o,
    output logic [ADDR_W:0]    skip_cnt_o,
    output logic [ADDR_W:0]    push_cnt_o,
    output logic               overflow_o
);

    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_DISP,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     child_q, child_d;
    logic [ADDR_W:0]   disp_cnt_q, disp_cnt_d;
    logic [ADDR_W:0]   skip_cnt_q, skip_cnt_d;
    logic [ADDR_W:0]   push_cnt_q, push_cnt_d;
    logic              ovf_q, ovf_d;

    logic              ran_re;
    logic              we;
    logic              dvalid;
    logic              done;

    // Advancing past the current entry: either the pass ends or we read
    // the next index. num_q is never 0 while scanning, so num_q-1 is safe.
    logic              last_idx;
    state_t            after_entry;
    logic [ADDR_W-1:0] idx_next;

    assign last_idx    = (idx_q == (num_q - IDX_ONE));
    assign after_entry = last_idx ? S_DONE : S_RD;
    assign idx_next    = last_idx ? idx_q : (idx_q + IDX_ONE);

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            idx_q      <= '0;
            pos_q      <= '0;
            addr_q     <= '0;
            child_q    <= '0;
            disp_cnt_q <= '0;
            skip_cnt_q <= '0;
            push_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            addr_q     <= addr_d;
            child_q    <= child_d;
            disp_cnt_q <= disp_cnt_d;
            skip_cnt_q <= skip_cnt_d;
            push_cnt_q <= push_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        addr_d     = addr_q;
        child_d    = child_q;
        disp_cnt_d = disp_cnt_q;
        skip_cnt_d = skip_cnt_q;
        push_cnt_d = push_cnt_q;
        ovf_d      = ovf_q;
        ran_re     = 1'b0;
        we         = 1'b0;
        dvalid     = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_d      = num_i;
                    idx_d      = '0;
                    disp_cnt_d = '0;
                    skip_cnt_d = '0;
                    push_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = (num_i != '0) ? S_RD : S_DONE;
                end
            end

            S_RD: begin
                ran_re  = 1'b1;
                state_d = S_CHK;
            end

            // st_rdata is the registered regfile output for idx_q
            S_CHK: begin
                if (bus.st_rdata[0]) begin
                    skip_cnt_d = skip_cnt_q + CNT_ONE;
                    idx_d      = idx_next;
                    state_d    = after_entry;
                end else begin
                    pos_d   = bus.st_rdata[DW-1 -: POS_W];
                    addr_d  = bus.st_rdata[ADDR_W:1];
                    state_d = S_DISP;
                end
            end

            S_DISP: begin
                dvalid = 1'b1;
                if (bus.disp_ready) begin
                    disp_cnt_d = disp_cnt_q + CNT_ONE;
                    state_d    = S_WAIT;
                end
            end

            // Responses are only honoured here; a stray strobe elsewhere
            // has no effect.
            S_WAIT: begin
                if (bus.resp_valid) begin
                    if (bus.resp_push) begin
                        child_d = bus.resp_state;
                        state_d = S_WB;
                    end else begin
                        idx_d   = idx_next;
                        state_d = after_entry;
                    end
                end
            end

            // Appends land beyond num_q, so they are not revisited this pass.
            S_WB: begin
                if (!bus.st_full) begin
                    we         = 1'b1;
                    push_cnt_d = push_cnt_q + CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
                idx_d   = idx_next;
                state_d = after_entry;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Data fields are zeroed outside their strobes so a reset leaves
    // every output at 0 regardless of stale registers.
    assign bus.st_ran_re   = ran_re;
    assign bus.st_ran_addr = ran_re ? idx_q : '0;
    assign bus.st_we       = we;
    assign bus.st_wdata    = we ? child_q : '0;
    assign bus.disp_valid  = dvalid;
    assign bus.disp_pos    = dvalid ? pos_q  : '0;
    assign bus.disp_addr   = dvalid ? addr_q : '0;
    assign bus.disp_idx    = dvalid ? idx_q  : '0;

    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o     = done;
    assign disp_cnt_o = disp_cnt_q;
    assign skip_cnt_o = skip_cnt_q;
    assign push_cnt_o = push_cnt_q;
    assign overflow_o = ovf_q;

endmodule
